// File: rtl/mem_bus_stage_pkg.sv
// Shared definitions for the memory-access stage: opcodes, FSM states, access sizes
// and small opcode-decoding helpers.
package mem_bus_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return is_load_op(op) || is_store_op(op);
    endfunction

    function automatic size_t op_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SZ_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SZ_HALF;
            default:                          return SZ_WORD;
        endcase
    endfunction

    function automatic logic op_signed(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LH_OP);
    endfunction

endpackage

// File: rtl/mem_bus_stage_lane_align.sv
// mem_lane_align: big-endian byte-lane steering. Produces lane enables, replicated
// store data, the sign/zero-extended load value and a misalignment indication.
module mem_lane_align
    import mem_bus_stage_pkg::*;
(
    input  logic [7:0]        aluop,
    input  logic [1:0]        addr_low,
    input  logic [RegBus-1:0] reg2,
    input  logic [RegBus-1:0] rdata,
    output logic [3:0]        sel,
    output logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] rdata_ext,
    output logic              misaligned
);

    // rbyte[n] is the byte at address offset n (offset 0 is the MSB lane).
    logic [7:0] rbyte [4];
    size_t      size;
    logic       sign;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = rdata[RegBus-1-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        size       = op_size(aluop);
        sign       = op_signed(aluop);
        sel        = 4'b1111;
        wdata      = reg2;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                sel       = 4'b1000 >> addr_low;
                wdata     = {4{reg2[7:0]}};
                rdata_ext = {{24{sign & rbyte[addr_low][7]}}, rbyte[addr_low]};
            end
            SZ_HALF: begin
                // addr_low[0] is ignored for lane selection; it only flags misalignment.
                sel        = addr_low[1] ? 4'b0011 : 4'b1100;
                wdata      = {2{reg2[15:0]}};
                rdata_ext  = addr_low[1] ? {{16{sign & rbyte[2][7]}}, rbyte[2], rbyte[3]}
                                         : {{16{sign & rbyte[0][7]}}, rbyte[0], rbyte[1]};
                misaligned = addr_low[0];
            end
            default: begin
                misaligned = |addr_low;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_stage.sv
// Memory-access stage: single-outstanding req/ack bus with timeout abort and stall.
// Optional MEM_ALIGN_CHECK_EN aborts misaligned halfword/word accesses without a bus cycle.
module mem_bus_stage
    import mem_bus_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [RegBus-1:0]     ex_wdata,
    input  logic [7:0]            ex_aluop,
    input  logic [RegBus-1:0]     ex_mem_addr,
    input  logic [RegBus-1:0]     ex_reg2,
    output logic [RegAddrBus-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [RegBus-1:0]     mem_wdata,
    output logic                  stallreq_mem,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [RegBus-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [RegBus-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [RegBus-1:0]     bus_rdata,
    output logic                  bus_err
);

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif
    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

    state_t            state_reg, state_next;
    logic [7:0]        count_reg, count_next, count_inc;
    logic              abort_reg, abort_next;
    logic [RegBus-1:0] load_result_reg, load_result_next;
    logic              bus_req_reg, bus_req_next;
    logic              bus_we_reg, bus_we_next;
    logic [RegBus-1:0] bus_addr_reg, bus_addr_next;
    logic [3:0]        bus_sel_reg, bus_sel_next;
    logic [RegBus-1:0] bus_wdata_reg, bus_wdata_next;
    logic              bus_err_reg, bus_err_next;

    logic              mem_op, load_op;
    logic [3:0]        lane_sel;
    logic [RegBus-1:0] lane_wdata, lane_rdata_ext;
    logic              misaligned;

    assign mem_op    = is_mem_op(ex_aluop);
    assign load_op   = is_load_op(ex_aluop);
    assign count_inc = count_reg + 8'd1;

    mem_lane_align u_lane_align (
        .aluop      (ex_aluop),
        .addr_low   (ex_mem_addr[1:0]),
        .reg2       (ex_reg2),
        .rdata      (bus_rdata),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .rdata_ext  (lane_rdata_ext),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            count_reg       <= 8'd0;
            abort_reg       <= 1'b0;
            load_result_reg <= '0;
            bus_req_reg     <= 1'b0;
            bus_we_reg      <= 1'b0;
            bus_addr_reg    <= '0;
            bus_sel_reg     <= 4'b0000;
            bus_wdata_reg   <= '0;
            bus_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            abort_reg       <= abort_next;
            load_result_reg <= load_result_next;
            bus_req_reg     <= bus_req_next;
            bus_we_reg      <= bus_we_next;
            bus_addr_reg    <= bus_addr_next;
            bus_sel_reg     <= bus_sel_next;
            bus_wdata_reg   <= bus_wdata_next;
            bus_err_reg     <= bus_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        abort_next       = abort_reg;
        load_result_next = load_result_reg;
        bus_req_next     = bus_req_reg;
        bus_we_next      = bus_we_reg;
        bus_addr_next    = bus_addr_reg;
        bus_sel_next     = bus_sel_reg;
        bus_wdata_next   = bus_wdata_reg;
        bus_err_next     = 1'b0;
        stallreq_mem     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (mem_op) begin
                    stallreq_mem = 1'b1;
                    if (ALIGN_CHECK && misaligned) begin
                        abort_next   = 1'b1;
                        bus_err_next = 1'b1;
                        state_next   = ST_DONE;
                    end else begin
                        bus_req_next   = 1'b1;
                        bus_we_next    = is_store_op(ex_aluop);
                        bus_addr_next  = {ex_mem_addr[RegBus-1:2], 2'b00};
                        bus_sel_next   = lane_sel;
                        bus_wdata_next = lane_wdata;
                        count_next     = 8'd0;
                        abort_next     = 1'b0;
                        state_next     = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stallreq_mem = 1'b1;
                // Ack is checked first so a simultaneous ack and timeout completes normally.
                if (bus_ack) begin
                    load_result_next = lane_rdata_ext;
                    bus_req_next     = 1'b0;
                    state_next       = ST_DONE;
                end else begin
                    count_next = count_inc;
                    if (count_inc == TIMEOUT_VAL) begin
                        bus_req_next = 1'b0;
                        bus_err_next = 1'b1;
                        abort_next   = 1'b1;
                        state_next   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        if (state_reg == ST_DONE && mem_op) begin
            if (load_op) begin
                mem_wdata = load_result_reg;
            end
            if (abort_reg) begin
                mem_wreg = 1'b0;
            end
        end
    end

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_sel   = bus_sel_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mem_bus_stage.sv
// Randomized bench for mem_bus_stage against an arithmetic model of lane steering,
// extension, stall length and timeout behaviour (honours MEM_ALIGN_CHECK_EN).
module tb_mem_bus_stage;

    localparam int TO = 4;

    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_SB  = 8'b11101000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;
    localparam logic [7:0] OP_ADD = 8'b00100000;
    localparam logic [7:0] OP_NOP = 8'b00000000;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic [7:0]  ex_aluop = '0;
    logic [31:0] ex_mem_addr = '0;
    logic [31:0] ex_reg2 = '0;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq_mem;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_aluop     (ex_aluop),
        .ex_mem_addr  (ex_mem_addr),
        .ex_reg2      (ex_reg2),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .stallreq_mem (stallreq_mem),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_sel      (bus_sel),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int op_bytes(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [7:0] op);
        return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
    endfunction

    // Lane offset of the access after dropping address bits illegal for its size.
    function automatic int lane_off(input logic [31:0] addr, input int n);
        return (int'(addr[1:0]) / n) * n;
    endfunction

    function automatic logic [3:0] model_sel(input logic [31:0] addr, input int n);
        int v;
        v = ((1 << n) - 1) << (4 - n - lane_off(addr, n));
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] reg2, input int n);
        if (n == 1) return {24'b0, reg2[7:0]} * 32'h01010101;
        if (n == 2) return {16'b0, reg2[15:0]} * 32'h00010001;
        return reg2;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int     n;
        longint v;
        longint span;
        n    = op_bytes(op);
        span = longint'(1) << (8 * n);
        v    = (longint'(rdata) >> ((4 - n - lane_off(addr, n)) * 8)) & (span - 1);
        if ((op == OP_LB || op == OP_LH) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // Entered one time unit after a rising edge with the DUT idle; leaves it the same way.
    // lat = BUSY cycle on which ack is driven (0 = never).
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] rdata, input int lat);
        int n;
        int busy;
        int stalls;
        int req_cycles;
        bit acked;
        bit misal;
        n           = op_bytes(op);
        ex_aluop    = op;
        ex_mem_addr = addr;
        ex_reg2     = reg2;
        ex_wdata    = wdata;
        ex_wd       = wd;
        ex_wreg     = wreg;
        bus_ack     = 1'b0;
        #1;
        if (n == 0) begin
            check("pt_stall", stallreq_mem, 0);
            check("pt_wd", mem_wd, wd);
            check("pt_wreg", mem_wreg, wreg);
            check("pt_wdata", mem_wdata, wdata);
            @(posedge clk); #1;
            check("pt_bus_req", bus_req, 0);
            $display("txn op=%h passthrough wd=%0d wdata=%h", op, wd, wdata);
            return;
        end
        misal  = ALIGN_CHK && (int'(addr[1:0]) % n != 0);
        stalls = 0;
        busy   = 0;
        req_cycles = 0;
        acked  = 1'b0;
        check("idle_bus_req", bus_req, 0);
        if (stallreq_mem) stalls++;
        bus_ack   = 1'($urandom_range(0, 1));  // stray ack in IDLE must be ignored
        bus_rdata = $urandom;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        if (misal) begin
            check("mis_bus_req", bus_req, 0);
        end else begin
            check("bus_addr", bus_addr, addr & 32'hFFFFFFFC);
            check("bus_sel", bus_sel, model_sel(addr, n));
            check("bus_we", bus_we, !op_load(op));
            if (!op_load(op)) check("bus_wdata", bus_wdata, model_wdata(reg2, n));
            for (int k = 1; k <= TO; k++) begin
                busy++;
                if (stallreq_mem) stalls++;
                if (bus_req) req_cycles++;
                if (k == lat) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata;
                end else begin
                    bus_rdata = $urandom;
                end
                @(posedge clk); #1;
                bus_ack = 1'b0;
                if (k == lat) begin
                    acked = 1'b1;
                    break;
                end
            end
            check("req_cycles", req_cycles, acked ? lat : TO);
        end
        check("stall_cycles", stalls, 1 + busy);
        check("done_stall", stallreq_mem, 0);
        check("done_bus_req", bus_req, 0);
        check("done_bus_err", bus_err, !acked);
        check("done_wd", mem_wd, wd);
        check("done_wreg", mem_wreg, acked ? wreg : 1'b0);
        if (!op_load(op)) check("done_wdata_st", mem_wdata, wdata);
        else if (acked) check("done_load", mem_wdata, model_load(op, addr, rdata));
        bus_ack   = 1'($urandom_range(0, 1));  // stray ack in DONE must be ignored
        bus_rdata = $urandom;
        @(posedge clk); #1;
        bus_ack  = 1'b0;
        ex_aluop = OP_NOP;
        check("after_bus_err", bus_err, 0);
        check("after_bus_req", bus_req, 0);
        $display("txn op=%h addr=%h lat=%0d acked=%0d mem_wdata=%h", op, addr, lat, acked, mem_wdata);
    endtask

    initial begin
        logic [7:0] ops [10];
        logic [7:0] op;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADD, OP_NOP};

        #1;
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_sel", bus_sel, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_mem_wd", mem_wd, 0);
        check("rst_mem_wreg", mem_wreg, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_stall", stallreq_mem, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        run_op(OP_ADD, 32'h0, 32'h0, 32'h12345678, 5'd5, 1'b1, 32'h0, 0);
        run_op(OP_LB, 32'h1001, 32'h0, 32'h0, 5'd3, 1'b1, 32'h11F23344, 1);
        run_op(OP_SH, 32'h2002, 32'hAAAABEEF, 32'h2002, 5'd0, 1'b0, 32'h0, 3);
        run_op(OP_LW, 32'h3000, 32'h0, 32'h0, 5'd7, 1'b1, 32'h0, 0);
        run_op(OP_LW, 32'h3004, 32'h0, 32'h0, 5'd8, 1'b1, 32'hCAFEF00D, TO);
        run_op(OP_LW, 32'h3002, 32'h0, 32'h0, 5'd9, 1'b1, 32'h01020304, 1);

        // Reset mid-BUSY: bus_req must drop without waiting for a clock edge.
        ex_aluop = OP_LW; ex_mem_addr = 32'h4000; ex_wd = 5'd4; ex_wreg = 1'b1;
        @(posedge clk); #1;
        check("rstmid_req_before", bus_req, 1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_req_async", bus_req, 0);
        ex_aluop = OP_NOP;
        @(posedge clk); #1;
        rst = 1'b1;
        check("rstmid_bus_err", bus_err, 0);
        $display("txn reset during BUSY");
        run_op(OP_LBU, 32'h0, 32'h0, 32'h0, 5'd6, 1'b1, 32'h80123456, 1);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 9)];
            run_op(op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                   $urandom, $urandom_range(0, TO + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_stage.md
# mem_bus_stage

Memory-access stage sitting between the EX/MEM pipeline register and `mem_wb`. Loads and stores are carried out over a single-outstanding req/ack data bus, with big-endian byte-lane steering and sign/zero extension. The pipeline is stalled until the bus access completes. Non-memory instructions pass through to the `mem_wb` inputs combinationally, with no stall.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of BUSY cycles without `bus_ack` before the access is aborted (range 1..255).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `ex_wd`  in  5  destination register address.
- `ex_wreg`  in  1  register write enable.
- `ex_wdata`  in  32  ALU result.
- `ex_aluop`  in  8  operation code.
- `ex_mem_addr`  in  32  effective byte address.
- `ex_reg2`  in  32  store data.
- `mem_wd`  out  5  to `mem_wb`.
- `mem_wreg`  out  1  to `mem_wb`.
- `mem_wdata`  out  32  to `mem_wb`.
- `stallreq_mem`  out  1  pipeline stall request.
- `bus_req`  out  1  access request, registered.
- `bus_we`  out  1  1 = write, registered.
- `bus_addr`  out  32  word address with `[1:0]`=0, registered.
- `bus_sel`  out  4  byte-lane enables, registered.
- `bus_wdata`  out  32  write data, registered.
- `bus_ack`  in  1  access complete; sampled only while `bus_req`=1.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.
- `bus_err`  out  1  one-cycle pulse on timeout abort.

## Operation
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. All other `ex_aluop` values are pass-through: `mem_*` = `ex_*` and `stallreq_mem`=0.
- State machine states: IDLE, BUSY, DONE.
  - IDLE with a memory op: `stallreq_mem`=1 combinationally. At the clock edge, load the bus registers, set `bus_req`=1, clear the timeout counter, and go to BUSY.
  - BUSY: `stallreq_mem`=1. On `bus_ack`: capture the extended load result, drop `bus_req`, go to DONE. Otherwise increment the counter. When the counter equals `TIMEOUT_CYCLES`: drop `bus_req`, pulse `bus_err`, set an abort flag, go to DONE.
  - DONE: `stallreq_mem`=0. `mem_wdata` is the captured load result for loads, or `ex_wdata` for stores. `mem_wreg` is `ex_wreg`, forced to 0 if the abort flag is set. Next state is IDLE.
- Byte lanes are big-endian. For byte accesses, `addr[1:0]` 00/01/10/11 selects `bus_sel` 1000/0100/0010/0001. For halfword accesses, `addr[1]` 0/1 selects 1100/0011. Word accesses use 1111.
- Store data is replicated: SB uses `{4{reg2[7:0]}}`, SH uses `{2{reg2[15:0]}}`, SW uses `reg2`.
- Loads extract the selected lane. LB and LH sign-extend; LBU and LHU zero-extend.
- The EX-side inputs are held stable by the stall throughout BUSY and DONE.

## Timing
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_sel`=0, `bus_wdata`=0, `bus_err`=0, state=IDLE, counter=0, load result register=0.
- `mem_*` follow the pass-through values, so under reset (EX-side inputs are zero from the EX/MEM register) `mem_wd`=0, `mem_wreg`=0, `mem_wdata`=0, `stallreq_mem`=0.
- Minimum memory-op latency is 3 cycles (IDLE, BUSY×1, DONE). `mem_wb` captures the result at the end of DONE.
- Simultaneous `bus_ack` and timeout: ack wins and no error is raised.
- `bus_ack` arriving in IDLE or DONE is ignored.
- Reset asserted mid-BUSY: `bus_req` drops immediately (asynchronous) and the transaction is discarded.
- Back-to-back memory ops: the next op issues from the IDLE that follows DONE. The bus is never requested twice without an intervening ack or abort.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A misaligned LH/LHU/SH (`addr[0]`=1) or LW/SW (`addr[1:0]`≠0) issues no bus access.
  - The FSM goes IDLE→DONE with the abort flag set.
  - `bus_err` pulses for one cycle, and `mem_wreg`=0.
- `MEM_ALIGN_CHECK_EN` undefined: the low address bits that are illegal for the access size are ignored and treated as 0.

## Structure
- Shared package (`defines.v`):
  - `EXE_LB_OP`=8'b11100000, `EXE_LBU_OP`=8'b11100100, `EXE_LH_OP`=8'b11100001, `EXE_LHU_OP`=8'b11100101, `EXE_LW_OP`=8'b11100011, `EXE_SB_OP`=8'b11101000, `EXE_SH_OP`=8'b11101001, `EXE_SW_OP`=8'b11101011.
  - State encodings, `RegBus` and `RegAddrBus`.
- One sub-module, `mem_lane_align`: a combinational block producing `bus_sel`, replicated write data, and the extended load data.

## Test plan
- ADD result 0x12345678 to register 5 with `ex_wreg`=1 → same cycle `mem_wdata`=0x12345678, `mem_wd`=5, `stallreq_mem`=0, `bus_req` stays 0.
- LB at addr 0x1001, `bus_rdata`=0x11F23344, ack on first BUSY cycle → `bus_addr`=0x1000, `bus_sel`=0100. DONE gives `mem_wdata`=0xFFFFFFF2, with stall high for exactly 2 cycles.
- SH at addr 0x2002, `reg2`=0xAAAABEEF, ack after 3 cycles → `bus_we`=1, `bus_sel`=0011, `bus_wdata`=0xBEEFBEEF, `bus_err`=0.
- LW with no ack and `TIMEOUT_CYCLES`=4 → `bus_req` high 4 cycles, `bus_err` one-cycle pulse, DONE with `mem_wreg`=0.
- LW, `rst` pulled low during BUSY → `bus_req`=0 immediately. After release, state is IDLE and a subsequent LBU of 0x80 returns 0x00000080.
- With `MEM_ALIGN_CHECK_EN`, LW at 0x3002 → no `bus_req`, `bus_err` pulses, `mem_wreg`=0.
